in_port_ctrl: RTL and testbench
===============================

# in_port_ctrl

Parametrised input-port controller for the N-way packet switch. It sits between one input FIFO and the crossbar/arbiter. It decodes the destination of each head flit into a one-hot request and holds that request until the arbiter grants. It then streams the packet through a valid/ready handshake and releases on the tail flit. Unlike the previous single-mode controller, it also drops packets with an invalid destination, truncates over-length packets, and counts drops.

## Interface
Parameters:
- PORTS, 4, number of crossbar output ports (≥2)
- MAX_LEN, 16, maximum flits per packet including head and tail (≥2)
- DST_W, $clog2(PORTS) (minimum 1), width of the destination field

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- empty  in  1  input FIFO empty
- cmd  in  2  command of the flit at the FIFO head: 00 idle, 01 body, 10 head, 11 tail
- dst  in  DST_W  destination field of the FIFO-head flit; meaningful only when cmd==head
- re  out  1  FIFO pop, combinational
- req  out  PORTS  one-hot request to the arbiter, registered
- gnt  in  PORTS  grant vector from the arbiter
- xb_valid  out  1  FIFO-head flit offered to the crossbar, combinational
- xb_ready  in  1  crossbar accepts the offered flit this cycle
- sel  out  PORTS  crossbar select, one-hot, registered
- drop_cnt  out  8  dropped-packet counter, saturating at 255
- err_len  out  1  sticky over-length flag

## Operation
- The FSM has four states: IDLE, REQ, FWD, DROP.
- Only flits with empty==0 are considered.
- IDLE:
  - head with dst<PORTS: req<=onehot(dst), go to REQ. The head is not popped.
  - head with dst≥PORTS: re=1 (pop the head), drop_cnt++, go to DROP.
  - stray body or tail: re=1, discard, stay in IDLE. No count.
- REQ: re=0, xb_valid=0.
  - When (gnt & req)!=0: sel<=req, len<=0, go to FWD.
  - Grant bits outside req are ignored.
- FWD:
  - xb_valid = !empty; re = xb_valid & xb_ready. A transfer is one cycle with both high.
  - Each transfer increments len. The head flit is counted.
  - Transfer of a tail flit: req<=0, sel<=0, go to IDLE.
  - Transfer that brings len to MAX_LEN with a non-tail flit: req<=0, sel<=0, err_len<=1, drop_cnt++, go to DROP.
  - A head cmd seen in FWD is forwarded as a body flit.
- DROP:
  - re = !empty; every flit is discarded.
  - Popping a tail flit returns to IDLE. A head cmd seen in DROP is treated as body.
- drop_cnt saturates at 255. err_len clears only on reset.
- len has width $clog2(MAX_LEN+1) and never wraps.

## Timing
- Reset values: state IDLE, req=0, sel=0, drop_cnt=0, err_len=0, len=0. re=0 and xb_valid=0 while rst is high.
- Reset mid-packet aborts immediately. The partially sent packet is not completed; the crossbar side handles truncation.
- Head visible at cycle t in IDLE → req valid at t+1.
- Grant sampled at t+1 → FWD at t+2; first xb_valid at t+2 if the FIFO is non-empty.
- Zero-stall packet of L flits: req asserted for L+1 cycles (REQ cycle plus L FWD cycles), from t+1 through t+L+1. req and sel drop at t+L+2.
- re is never high while empty==1.
- In FWD, empty==1 stalls with xb_valid=0; len and state are held.
- xb_ready high with no valid flit has no effect.
- A tail at len==MAX_LEN-1 (len reaching MAX_LEN on the tail itself) is a legal packet: no error, no drop.
- Back-to-back packets: after the tail transfer, the next head can raise req no earlier than the following cycle. There is one idle cycle minimum between packets.

## Structure
- Shared header sw.vh holds:
  - CMD_IDLE/CMD_BODY/CMD_HEAD/CMD_TAIL localparams
  - FSM state encodings
  - PORT width macro
- Sub-module onehot_dec (DST_W → PORTS, with a valid output for dst<PORTS) produces both req and the invalid-destination detect.
- FSM, length counter and drop counter stay in in_port_ctrl.

## Test plan
- Legal packet: head dst=2 plus 2 body plus tail, gnt=0100 one cycle after req, xb_ready=1 → req=0100, then sel=0100. Exactly 4 pops, back to IDLE, drop_cnt=0.
- Invalid destination with PORTS=3, dst=3: packet of head plus 3 body plus tail → all 5 flits popped, xb_valid never high, drop_cnt=1, req stays 0.
- Over-length with MAX_LEN=4: packet of 6 flits → 4 transfers, err_len=1, drop_cnt=1. Remaining 2 flits popped in DROP, then IDLE.
- Backpressure: xb_ready toggling 1/0 and empty gaps mid-packet → no pop without ready, no duplicate or lost flit, len correct at tail.
- Grant mismatch then match: req=0010, gnt=0001 for 3 cycles → stays in REQ. gnt=0010 → FWD the next cycle.
- Async reset asserted mid-FWD, off-clock-edge → req, sel, re and xb_valid go to 0 immediately. Stray body flits after reset are popped and discarded in IDLE.

Source files
------------

// File: rtl/in_port_ctrl_pkg.sv
// in_port_ctrl_pkg: flit command codes, FSM states and destination-width helper shared by the input-port controller
package in_port_ctrl_pkg;
  typedef enum logic [1:0] {CMD_IDLE, CMD_BODY, CMD_HEAD, CMD_TAIL} cmd_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FWD, S_DROP} state_t;
  function automatic int dst_width(input int ports);
    return ports > 2 ? $clog2(ports) : 1;
  endfunction
endpackage

// File: rtl/in_port_ctrl_onehot_dec.sv
// in_port_ctrl_onehot_dec: dst -> one-hot port vector (zero when out of range) plus valid = dst<PORTS
module in_port_ctrl_onehot_dec #(
  parameter int PORTS = 4,
  parameter int DST_W = 2
) (
  input  logic [DST_W-1:0] dst,
  output logic [PORTS-1:0] onehot,
  output logic             valid
);
  assign valid = 32'(dst) < PORTS;
  assign onehot = valid ? {{(PORTS-1){1'b0}}, 1'b1} << dst : '0;
endmodule

// File: rtl/in_port_ctrl.sv
// in_port_ctrl: FIFO-head flits -> one-hot req/grant -> valid/ready crossbar stream; ports clk,rst,empty,cmd,dst,re,req,gnt,xb_valid,xb_ready,sel,drop_cnt,err_len
module in_port_ctrl
  import in_port_ctrl_pkg::*;
#(
  parameter int PORTS   = 4,
  parameter int MAX_LEN = 16,
  parameter int DST_W   = dst_width(PORTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             empty,
  input  logic [1:0]       cmd,
  input  logic [DST_W-1:0] dst,
  output logic             re,
  output logic [PORTS-1:0] req,
  input  logic [PORTS-1:0] gnt,
  output logic             xb_valid,
  input  logic             xb_ready,
  output logic [PORTS-1:0] sel,
  output logic [7:0]       drop_cnt,
  output logic             err_len
);
  localparam int LW = $clog2(MAX_LEN + 1);
  state_t state;
  cmd_t c;
  logic [LW-1:0] len;
  logic [PORTS-1:0] dec;
  logic [7:0] drop_nxt;
  logic dst_ok, vld, xfer, last;
  in_port_ctrl_onehot_dec #(.PORTS(PORTS), .DST_W(DST_W)) u_dec (
    .dst(dst),
    .onehot(dec),
    .valid(dst_ok)
  );
  assign c = cmd_t'(cmd);
  assign vld = !empty && !rst;
  assign xb_valid = state == S_FWD && vld;
  assign xfer = xb_valid && xb_ready;
  assign last = len == LW'(MAX_LEN - 1);
  assign drop_nxt = drop_cnt + 8'(drop_cnt != 8'hff);
  assign re = state == S_IDLE ? vld && !(c == CMD_HEAD && dst_ok) :
              state == S_FWD  ? xfer :
              state == S_DROP && vld;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= S_IDLE;
      req      <= '0;
      sel      <= '0;
      len      <= '0;
      drop_cnt <= '0;
      err_len  <= 1'b0;
    end else
      case (state)
        S_IDLE:
          if (vld && c == CMD_HEAD) begin
            if (dst_ok) begin
              req   <= dec;
              state <= S_REQ;
            end else begin
              drop_cnt <= drop_nxt;
              state    <= S_DROP;
            end
          end
        S_REQ:
          if (|(gnt & req)) begin
            sel   <= req;
            len   <= '0;
            state <= S_FWD;
          end
        S_FWD:
          if (xfer) begin
            len <= len + 1'b1;
            if (c == CMD_TAIL || last) begin
              req   <= '0;
              sel   <= '0;
              state <= c == CMD_TAIL ? S_IDLE : S_DROP;
            end
            if (c != CMD_TAIL && last) begin
              err_len  <= 1'b1;
              drop_cnt <= drop_nxt;
            end
          end
        S_DROP:
          if (vld && c == CMD_TAIL) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
endmodule

// File: tb/tb_in_port_ctrl.sv
// tb_in_port_ctrl: scoreboard bench for in_port_ctrl with PORTS=3, MAX_LEN=4 and a modelled input FIFO
module tb_in_port_ctrl;
  localparam int P = 3;
  localparam int ML = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic empty = 1'b1;
  logic xb_ready = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic [1:0] dst = 2'b00;
  logic [P-1:0] gnt = '0;
  logic re, xb_valid, err_len;
  logic [P-1:0] req, sel;
  logic [7:0] drop_cnt;
  logic [3:0] fifo[$];
  logic [7:0] sb[$];
  int checks = 0;
  int failures = 0;
  int pops = 0;
  int cyc = 0;
  logic any_xv = 1'b0;
  logic any_req = 1'b0;

  always #5 clk = ~clk;

  in_port_ctrl #(.PORTS(P), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst), .empty(empty), .cmd(cmd), .dst(dst), .re(re),
    .req(req), .gnt(gnt), .xb_valid(xb_valid), .xb_ready(xb_ready),
    .sel(sel), .drop_cnt(drop_cnt), .err_len(err_len)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp_v);
    end
  endtask

  task automatic drive(input logic gap, input logic rdy, input logic [P-1:0] g);
    empty = gap || fifo.size() == 0;
    {cmd, dst} = fifo.size() > 0 ? fifo[0] : 4'h0;
    xb_ready = rdy;
    gnt = g;
  endtask

  task automatic step(input logic gap, input logic rdy, input logic [P-1:0] g);
    logic popped;
    logic [3:0] dummy;
    drive(gap, rdy, g);
    @(negedge clk);
    cyc++;
    any_xv |= xb_valid;
    any_req |= |req;
    if (empty) chk("re_while_empty", 32'(re), 0);
    if (xb_valid && xb_ready) begin
      if (sb.size() == 0) chk("unexpected_xfer", sb.size(), 1);
      else chk("xfer_flit", {req, sel, cmd}, sb.pop_front());
    end
    popped = re;
    @(posedge clk);
    #1;
    if (popped) begin
      dummy = fifo.pop_front();
      pops++;
    end
  endtask

  task automatic send_pkt(input logic [1:0] d, input int n);
    logic [P-1:0] oh;
    logic [1:0] c;
    oh = 3'b001 << d;
    for (int i = 0; i < n; i++) begin
      c = i == 0 ? 2'b10 : i == n - 1 ? 2'b11 : 2'b01;
      fifo.push_back({c, d});
      if (32'(d) < P && i < ML) sb.push_back({oh, oh, c});
    end
  endtask

  task automatic drain(input logic [P-1:0] g, input logic bp, input int budget);
    int n;
    n = 0;
    while (fifo.size() > 0 && n < budget) begin
      step(bp && (cyc % 5 == 3), !bp || cyc[0], g);
      n++;
    end
    chk("drain_left", fifo.size(), 0);
    step(1'b0, 1'b1, g);
    step(1'b0, 1'b1, g);
    chk("sb_left", sb.size(), 0);
  endtask

  initial begin
    int p0;
    empty = 1'b0;
    cmd = 2'b01;
    xb_ready = 1'b1;
    #12;
    chk("rst_req", req, 0);
    chk("rst_sel", sel, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_err", 32'(err_len), 0);
    chk("rst_re", 32'(re), 0);
    chk("rst_xv", 32'(xb_valid), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    send_pkt(2'd2, 4);
    p0 = pops;
    step(1'b0, 1'b1, 3'b000);
    chk("s1_req", req, 3'b100);
    chk("s1_head_kept", pops - p0, 0);
    step(1'b0, 1'b1, 3'b100);
    chk("s1_sel", sel, 3'b100);
    drain(3'b100, 1'b0, 100);
    chk("s1_pops", pops - p0, 4);
    chk("s1_clr", {req, sel}, 0);
    chk("s1_drop", drop_cnt, 0);
    chk("s1_err", 32'(err_len), 0);

    send_pkt(2'd3, 5);
    p0 = pops;
    any_xv = 1'b0;
    any_req = 1'b0;
    drain(3'b000, 1'b0, 100);
    chk("s2_pops", pops - p0, 5);
    chk("s2_drop", drop_cnt, 1);
    chk("s2_no_xv", 32'(any_xv), 0);
    chk("s2_no_req", 32'(any_req), 0);

    send_pkt(2'd1, 6);
    p0 = pops;
    drain(3'b010, 1'b0, 100);
    chk("s3_pops", pops - p0, 6);
    chk("s3_err", 32'(err_len), 1);
    chk("s3_drop", drop_cnt, 2);
    chk("s3_clr", {req, sel}, 0);

    send_pkt(2'd0, 4);
    send_pkt(2'd2, 3);
    p0 = pops;
    drain(3'b111, 1'b1, 200);
    chk("s4_pops", pops - p0, 7);
    chk("s4_drop", drop_cnt, 2);

    send_pkt(2'd1, 3);
    step(1'b0, 1'b1, 3'b000);
    repeat (3) begin
      step(1'b0, 1'b1, 3'b001);
      chk("s5_hold_req", req, 3'b010);
      chk("s5_no_fwd", 32'(xb_valid), 0);
    end
    step(1'b0, 1'b1, 3'b010);
    chk("s5_fwd", 32'(xb_valid), 1);
    drain(3'b010, 1'b0, 100);

    send_pkt(2'd2, 4);
    step(1'b0, 1'b1, 3'b000);
    step(1'b0, 1'b1, 3'b100);
    step(1'b0, 1'b1, 3'b100);
    chk("s6_mid_sel", sel, 3'b100);
    drive(1'b0, 1'b1, 3'b100);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_async", {req, sel, re, xb_valid}, 0);
    sb.delete();
    @(negedge clk) rst = 1'b0;
    chk("s6_err_clr", 32'(err_len), 0);
    chk("s6_drop_clr", drop_cnt, 0);
    p0 = pops;
    any_xv = 1'b0;
    drain(3'b000, 1'b0, 100);
    chk("s6_stray_pops", pops - p0, 3);
    chk("s6_no_xv", 32'(any_xv), 0);
    chk("s6_drop", drop_cnt, 0);

    repeat (257) send_pkt(2'd3, 2);
    drain(3'b000, 1'b0, 2000);
    chk("s7_sat", drop_cnt, 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
